// File: rtl/regex_pc_fifo.sv
// Circular PC queue that feeds (cc_id, pc) pairs back into regex_cpu.
// It also keeps per-context occupancy counts so the controller can advance character windows.
module regex_pc_fifo #(
    parameter int PC_WIDTH   = 9,
    parameter int CC_ID_BITS = 2,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_pc_valid,
    input  logic [CC_ID_BITS-1:0]   in_cc_id,
    input  logic [PC_WIDTH-1:0]     in_pc,
    output logic                    in_pc_ready,
    output logic                    out_pc_valid,
    output logic [CC_ID_BITS-1:0]   out_cc_id,
    output logic [PC_WIDTH-1:0]     out_pc,
    input  logic                    out_pc_ready,
    output logic [DEPTH_LOG2:0]     count,
    output logic [2**CC_ID_BITS-1:0] cc_pending
);

    localparam int DEPTH   = 2**DEPTH_LOG2;
    localparam int NUM_CC  = 2**CC_ID_BITS;
    localparam int ENTRY_W = CC_ID_BITS + PC_WIDTH;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_cc_cnt [NUM_CC];

    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;
    logic [CC_ID_BITS-1:0] w_head_cc;

    assign in_pc_ready  = (r_count != C_FULL);
    assign out_pc_valid = (r_count != '0);
    assign w_push       = in_pc_valid & in_pc_ready;
    assign w_pop        = out_pc_valid & out_pc_ready;

    // The head is read combinationally, so an entry is visible the cycle after it lands.
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_cc = w_head[ENTRY_W-1:PC_WIDTH];
    assign out_cc_id = w_head_cc;
    assign out_pc    = w_head[PC_WIDTH-1:0];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_cc_id, in_pc};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CC; gi++) begin : g_cc
            logic w_inc;
            logic w_dec;

            assign w_inc = w_push && (in_cc_id == CC_ID_BITS'(gi));
            assign w_dec = w_pop && (w_head_cc == CC_ID_BITS'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cc_cnt[gi] <= '0;
                end else begin
                    case ({w_inc, w_dec})
                        2'b10:   r_cc_cnt[gi] <= r_cc_cnt[gi] + 1'b1;
                        2'b01:   r_cc_cnt[gi] <= r_cc_cnt[gi] - 1'b1;
                        default: r_cc_cnt[gi] <= r_cc_cnt[gi];
                    endcase
                end
            end

            assign cc_pending[gi] = (r_cc_cnt[gi] != '0);
        end
    endgenerate

endmodule

// File: tb/tb_regex_pc_fifo.sv
// Directed bench for regex_pc_fifo: vector table for order/latency/simultaneous push-pop,
// plus hand sequences for reset, full/wrap and mid-operation reset.
module tb_regex_pc_fifo;

    logic       clk;
    logic       rst;
    logic       in_pc_valid;
    logic [1:0] in_cc_id;
    logic [8:0] in_pc;
    logic       in_pc_ready;
    logic       out_pc_valid;
    logic [1:0] out_cc_id;
    logic [8:0] out_pc;
    logic       out_pc_ready;
    logic [4:0] count;
    logic [3:0] cc_pending;

    int n_vec;
    int n_err;

    regex_pc_fifo #(.PC_WIDTH(9), .CC_ID_BITS(2), .DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_pc_valid  (in_pc_valid),
        .in_cc_id     (in_cc_id),
        .in_pc        (in_pc),
        .in_pc_ready  (in_pc_ready),
        .out_pc_valid (out_pc_valid),
        .out_cc_id    (out_cc_id),
        .out_pc       (out_pc),
        .out_pc_ready (out_pc_ready),
        .count        (count),
        .cc_pending   (cc_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [1:0] cc;
        logic [8:0] pc;
        logic       pop;
        logic       exp_rdy;
        logic       exp_vld;
        logic [4:0] exp_cnt;
        logic [3:0] exp_pend;
        logic       chk_head;
        logic [1:0] exp_cc;
        logic [8:0] exp_pc;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic status(input string tag, input logic rdy, input logic vld,
                          input logic [4:0] cnt, input logic [3:0] pend);
        chk({tag, ".ready"},   32'(in_pc_ready),  32'(rdy));
        chk({tag, ".valid"},   32'(out_pc_valid), 32'(vld));
        chk({tag, ".count"},   32'(count),        32'(cnt));
        chk({tag, ".pending"}, 32'(cc_pending),   32'(pend));
    endtask

    task automatic head(input string tag, input logic [1:0] cc, input logic [8:0] pc);
        chk({tag, ".cc"}, 32'(out_cc_id), 32'(cc));
        chk({tag, ".pc"}, 32'(out_pc),    32'(pc));
    endtask

    // Drive inputs at negedge, let one rising edge pass, return at the next negedge.
    task automatic cycle(input logic push, input logic [1:0] cc, input logic [8:0] pc, input logic pop);
        in_pc_valid  = push;
        in_cc_id     = cc;
        in_pc        = pc;
        out_pc_ready = pop;
        @(posedge clk);
        @(negedge clk);
        in_pc_valid  = 1'b0;
        out_pc_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        in_pc_valid  = 1'b0;
        in_cc_id     = 2'd0;
        in_pc        = 9'd0;
        out_pc_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;

        //                 push  cc    pc       pop   rdy   vld   cnt    pend     head  hcc   hpc
        vecs[0]  = '{1'b1, 2'd1, 9'h06E, 1'b0, 1'b1, 1'b1, 5'd1, 4'b0010, 1'b1, 2'd1, 9'h06E};
        vecs[1]  = '{1'b1, 2'd1, 9'h0A3, 1'b0, 1'b1, 1'b1, 5'd2, 4'b0010, 1'b1, 2'd1, 9'h06E};
        vecs[2]  = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b1, 5'd1, 4'b0010, 1'b1, 2'd1, 9'h0A3};
        vecs[3]  = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 2'd0, 9'h000};
        vecs[4]  = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 2'd0, 9'h000};
        vecs[5]  = '{1'b1, 2'd0, 9'h010, 1'b0, 1'b1, 1'b1, 5'd1, 4'b0001, 1'b1, 2'd0, 9'h010};
        vecs[6]  = '{1'b1, 2'd2, 9'h020, 1'b0, 1'b1, 1'b1, 5'd2, 4'b0101, 1'b1, 2'd0, 9'h010};
        vecs[7]  = '{1'b1, 2'd3, 9'h030, 1'b0, 1'b1, 1'b1, 5'd3, 4'b1101, 1'b1, 2'd0, 9'h010};
        vecs[8]  = '{1'b1, 2'd2, 9'h021, 1'b1, 1'b1, 1'b1, 5'd3, 4'b1100, 1'b1, 2'd2, 9'h020};
        vecs[9]  = '{1'b1, 2'd2, 9'h022, 1'b1, 1'b1, 1'b1, 5'd3, 4'b1100, 1'b1, 2'd3, 9'h030};
        vecs[10] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b1, 5'd2, 4'b0100, 1'b1, 2'd2, 9'h021};
        vecs[11] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b1, 5'd1, 4'b0100, 1'b1, 2'd2, 9'h022};
        vecs[12] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 2'd0, 9'h000};
        // push+pop while empty: no fall-through, the push alone takes effect
        vecs[13] = '{1'b1, 2'd1, 9'h055, 1'b1, 1'b1, 1'b1, 5'd1, 4'b0010, 1'b1, 2'd1, 9'h055};
        vecs[14] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 2'd0, 9'h000};

        // Reset/idle: held low for two cycles, then released.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            status($sformatf("reset%0d", i), 1'b1, 1'b0, 5'd0, 4'b0000);
        end
        rst = 1'b1;
        @(negedge clk);
        status("idle", 1'b1, 1'b0, 5'd0, 4'b0000);

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].push, vecs[i].cc, vecs[i].pc, vecs[i].pop);
            $display("vec %0d: push=%0b cc=%0d pc=0x%03h pop=%0b -> cnt=%0d pend=%04b head=%0d/0x%03h",
                     i, vecs[i].push, vecs[i].cc, vecs[i].pc, vecs[i].pop,
                     count, cc_pending, out_cc_id, out_pc);
            status($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_vld,
                   vecs[i].exp_cnt, vecs[i].exp_pend);
            if (vecs[i].chk_head) head($sformatf("vec%0d", i), vecs[i].exp_cc, vecs[i].exp_pc);
        end

        // Full/wrap: fill, reject a 17th offer, pop 4, wrap the write pointer, drain.
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'(i % 4), 9'(i), 1'b0);
        $display("full: cnt=%0d ready=%0b", count, in_pc_ready);
        status("full", 1'b0, 1'b1, 5'd16, 4'b1111);
        cycle(1'b1, 2'd0, 9'h1FF, 1'b0);
        $display("offer17: cnt=%0d ready=%0b", count, in_pc_ready);
        status("offer17", 1'b0, 1'b1, 5'd16, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            head($sformatf("pop%0d", i), 2'(i % 4), 9'(i));
            cycle(1'b0, 2'd0, 9'd0, 1'b1);
            $display("pop %0d: cnt=%0d", i, count);
        end
        chk("after_pop4.ready", 32'(in_pc_ready), 32'd1);
        for (int i = 16; i < 20; i++) cycle(1'b1, 2'(i % 4), 9'(i), 1'b0);
        $display("refill: cnt=%0d", count);
        status("refill", 1'b0, 1'b1, 5'd16, 4'b1111);
        for (int i = 4; i < 20; i++) begin
            head($sformatf("drain%0d", i), 2'(i % 4), 9'(i));
            cycle(1'b0, 2'd0, 9'd0, 1'b1);
        end
        $display("drained: cnt=%0d", count);
        status("drained", 1'b1, 1'b0, 5'd0, 4'b0000);

        // Reset mid-operation: 7 entries, async pulse between edges.
        for (int i = 0; i < 7; i++) cycle(1'b1, 2'(i % 3), 9'(9'h100 + i), 1'b0);
        status("seven", 1'b1, 1'b1, 5'd7, 4'b0111);
        #1 rst = 1'b0;
        #1;
        $display("async reset: cnt=%0d vld=%0b pend=%04b", count, out_pc_valid, cc_pending);
        status("async_rst", 1'b1, 1'b0, 5'd0, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        cycle(1'b1, 2'd3, 9'h1AB, 1'b0);
        status("post_rst_push", 1'b1, 1'b1, 5'd1, 4'b1000);
        head("post_rst_head", 2'd3, 9'h1AB);
        cycle(1'b0, 2'd0, 9'd0, 1'b1);
        $display("post reset pop: cnt=%0d", count);
        status("post_rst_pop", 1'b1, 1'b0, 5'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
